// File: rtl/maskshare_fifo_arb_pkg.sv
// maskshare_fifo_arb_pkg: arbiter FSM state encoding and statistics counter width
package maskshare_fifo_arb_pkg;
  typedef enum logic {MSA_IDLE = 1'b0, MSA_BUSY = 1'b1} msa_state_e;
  localparam int MSA_CNT_BW = 16;
endpackage

// File: rtl/maskshare_fifo_arb_rr_pick.sv
// maskshare_fifo_arb_rr_pick: round-robin first-valid picker (rotate, find-first-one, un-rotate)
module maskshare_fifo_arb_rr_pick #(
  parameter int N  = 4,
  parameter int BW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [BW-1:0] ptr,
  output logic          any,
  output logic [BW-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [BW-1:0]  ffo;
  logic [BW:0]    sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    ffo = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) ffo = BW'(i);
    sum = {1'b0, ffo} + {1'b0, ptr};
    idx = (sum >= (BW+1)'(N)) ? BW'(sum - (BW+1)'(N)) : sum[BW-1:0];
    any = |req;
  end
endmodule

// File: rtl/maskshare_fifo_arb.sv
// maskshare_fifo_arb: packet-locked round-robin arbiter for one FIFO write port
// `MASKSHARE_ARB_STATS_EN adds saturating pkt_cnt/stall_cnt outputs
module maskshare_fifo_arb
  import maskshare_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_BW  = 2,
  parameter int DATA_BW = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       abort,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_BW-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       gnt_valid,
  output logic [REQ_BW-1:0]          gnt_idx,
  input  logic                       fifo_full,
  output logic                       fifo_push,
  output logic [DATA_BW-1:0]         fifo_wdata
`ifdef MASKSHARE_ARB_STATS_EN
  ,
  output logic [MSA_CNT_BW-1:0]      pkt_cnt,
  output logic [MSA_CNT_BW-1:0]      stall_cnt
`endif
);
  msa_state_e          state_q, state_d;
  logic [REQ_BW-1:0]   gnt_idx_q, gnt_idx_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic                pick_any, busy, accept, done;
  maskshare_fifo_arb_rr_pick #(.N(NUM_REQ), .BW(REQ_BW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );
  // Ready is withheld during abort so a requester never sees a beat taken that was not pushed
  always_comb begin
    busy       = state_q == MSA_BUSY;
    accept     = busy & req_valid[gnt_idx_q] & ~fifo_full & ~abort;
    done       = accept & req_last[gnt_idx_q];
    req_ready  = (busy & ~fifo_full & ~abort) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
    fifo_push  = accept;
    fifo_wdata = accept ? req_data[gnt_idx_q*DATA_BW +: DATA_BW] : '0;
    gnt_valid  = busy;
    gnt_idx    = gnt_idx_q;
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (abort) state_d = MSA_IDLE;
    else if (!busy && pick_any) begin
      state_d   = MSA_BUSY;
      gnt_idx_d = pick_idx;
    end else if (done) begin
      state_d  = MSA_IDLE;
      rr_ptr_d = (gnt_idx_q == REQ_BW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + REQ_BW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= MSA_IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
`ifdef MASKSHARE_ARB_STATS_EN
  logic [MSA_CNT_BW-1:0] pkt_cnt_q, pkt_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    pkt_cnt_d   = (done && !(&pkt_cnt_q)) ? pkt_cnt_q + 1'b1 : pkt_cnt_q;
    stall_cnt_d = (busy && req_valid[gnt_idx_q] && fifo_full && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_maskshare_fifo_arb.sv
// tb_maskshare_fifo_arb: directed scenarios plus randomized traffic checked against a round-robin reference model
module tb_maskshare_fifo_arb;
  localparam int N  = 4;
  localparam int BW = 2;
  localparam int DW = 8;
  logic              clk = 1'b0;
  logic              rst_n, abort, fifo_full;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N*DW-1:0]   req_data;
  logic              gnt_valid, fifo_push;
  logic [BW-1:0]     gnt_idx;
  logic [DW-1:0]     fifo_wdata;
`ifdef MASKSHARE_ARB_STATS_EN
  logic [15:0]       pkt_cnt, stall_cnt;
`endif
  maskshare_fifo_arb #(.NUM_REQ(N), .REQ_BW(BW), .DATA_BW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata)
`ifdef MASKSHARE_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  // Reference model: grant held flag, grantee and round-robin start point
  int m_busy, m_g, m_ptr;
  typedef struct {int idx; int data; int t;} push_t;
  push_t plog[$];
  function automatic int pick();
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic bit m_accept();
    return m_busy != 0 && req_valid[m_g] && !fifo_full && !abort;
  endfunction
  task automatic advance();
    push_t e;
    int p;
    bit acc;
    acc = m_accept();
    if (fifo_push) begin
      e.idx = int'(gnt_idx); e.data = int'(fifo_wdata); e.t = cyc;
      plog.push_back(e);
    end
    if (abort) m_busy = 0;
    else if (m_busy == 0) begin
      p = pick();
      if (p >= 0) begin m_busy = 1; m_g = p; end
    end else if (acc && req_last[m_g]) begin
      m_ptr = (m_g + 1) % N;
      m_busy = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic step();
    @(negedge clk);
    advance();
  endtask
  task automatic do_reset();
    abort = 0; fifo_full = 0; req_valid = '0; req_last = '0; req_data = '0;
    @(posedge clk); #1;
    rst_n = 0; #2; rst_n = 1;
    m_busy = 0; m_g = 0; m_ptr = 0;
    plog.delete();
  endtask
  task automatic test_reset();
    rst_n = 0; abort = 0; fifo_full = 0;
    req_valid = '1; req_last = '0; req_data = 32'h44332211;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", fifo_push); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid: got %b want 0", gnt_valid); end
    checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_gnt_idx: got %0d want 0", gnt_idx); end
    @(posedge clk); #1;
    rst_n = 1; m_busy = 0; m_g = 0; m_ptr = 0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0 || fifo_push !== 1'b0) begin errors++; $display("FAIL first_idle_cycle: ready=%b push=%b want 0000/0", req_ready, fifo_push); end
    advance();
    checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin errors++; $display("FAIL first_grant: gv=%b idx=%0d want 1/0", gnt_valid, gnt_idx); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_ready: got %b want 0001", req_ready); end
  endtask
  task automatic test_packets();
    int beat [N];
    logic [N-1:0] acc;
    do_reset();
    for (int i = 0; i < N; i++) beat[i] = 0;
    req_valid = '1;
    for (int c = 0; c < 60 && plog.size() < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        req_data[i*DW +: DW] = DW'(i * 16 + beat[i]);
        req_last[i] = (beat[i] == 2);
      end
      @(negedge clk);
      acc = req_ready & req_valid;
      advance();
      for (int i = 0; i < N; i++) if (acc[i]) begin
        beat[i]++;
        if (beat[i] == 3) req_valid[i] = 1'b0;
      end
    end
    checks++; if (plog.size() != 12) begin errors++; $display("FAIL pkt_count_timeout: got %0d beats want 12", plog.size()); end
    for (int k = 0; k < 12 && k < plog.size(); k++) begin
      checks++;
      if (plog[k].idx != k / 3 || plog[k].data != (k / 3) * 16 + k % 3) begin
        errors++; $display("FAIL pkt_order[%0d]: got idx=%0d data=%0h want idx=%0d data=%0h", k, plog[k].idx, plog[k].data, k / 3, (k / 3) * 16 + k % 3);
      end
      if (k > 0) begin
        checks++;
        if (plog[k].t - plog[k-1].t != ((k % 3 == 0) ? 2 : 1)) begin
          errors++; $display("FAIL pkt_spacing[%0d]: got gap %0d want %0d", k, plog[k].t - plog[k-1].t, (k % 3 == 0) ? 2 : 1);
        end
      end
    end
`ifdef MASKSHARE_ARB_STATS_EN
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL pkt_cnt: got %0d want 4", pkt_cnt); end
`endif
  endtask
  task automatic test_wrap();
    do_reset();
    req_valid = 4'b1000; req_last = 4'b1000; req_data = 32'h77000000;
    step();
    checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3) begin errors++; $display("FAIL wrap_grant3: gv=%b idx=%0d want 1/3", gnt_valid, gnt_idx); end
    req_valid = 4'b1101; req_last = 4'b1000;
    @(negedge clk);
    checks++; if (fifo_push !== 1'b1 || fifo_wdata !== 8'h77) begin errors++; $display("FAIL wrap_push: push=%b data=%0h want 1/77", fifo_push, fifo_wdata); end
    advance();
    req_valid = 4'b0101;
    step();
    checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin errors++; $display("FAIL wrap_next_grant: gv=%b idx=%0d want 1/0", gnt_valid, gnt_idx); end
  endtask
  task automatic test_full();
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h0000A500;
    step();
    step();
    fifo_full = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_push !== 1'b0 || req_ready !== 4'b0 || gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
        errors++; $display("FAIL full_hold[%0d]: push=%b ready=%b gv=%b idx=%0d want 0/0000/1/1", c, fifo_push, req_ready, gnt_valid, gnt_idx);
      end
      advance();
    end
`ifdef MASKSHARE_ARB_STATS_EN
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
    fifo_full = 0; req_last = 4'b0010;
    @(negedge clk);
    checks++; if (fifo_push !== 1'b1 || fifo_wdata !== 8'hA5) begin errors++; $display("FAIL full_release: push=%b data=%0h want 1/a5", fifo_push, fifo_wdata); end
    advance();
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL full_done_idle: gv=%b want 0", gnt_valid); end
  endtask
  task automatic test_abort();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h44332211;
    step();
    step();
    req_valid = 4'b0111; req_last = 4'b0000;
    step();
    checks++; if (gnt_idx !== 2'd1) begin errors++; $display("FAIL abort_pre_grant: idx=%0d want 1", gnt_idx); end
    step();
    abort = 1;
    @(negedge clk);
    checks++; if (fifo_push !== 1'b0 || fifo_wdata !== 8'h0) begin errors++; $display("FAIL abort_push: push=%b data=%0h want 0/0", fifo_push, fifo_wdata); end
    advance();
    abort = 0;
    @(negedge clk);
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: gv=%b want 0", gnt_valid); end
    advance();
    checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin errors++; $display("FAIL abort_regrant: gv=%b idx=%0d want 1/1", gnt_valid, gnt_idx); end
  endtask
  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000; req_data = 32'h00C30000;
    step();
    step();
    #2 rst_n = 0;
    #1;
    checks++;
    if (gnt_valid !== 1'b0 || req_ready !== 4'b0 || fifo_push !== 1'b0 || gnt_idx !== 2'd0) begin
      errors++; $display("FAIL async_reset: gv=%b ready=%b push=%b idx=%0d want 0/0000/0/0", gnt_valid, req_ready, fifo_push, gnt_idx);
    end
`ifdef MASKSHARE_ARB_STATS_EN
    checks++; if (pkt_cnt !== 16'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_cnt: pkt=%0d stall=%0d want 0/0", pkt_cnt, stall_cnt); end
`endif
    #2 rst_n = 1;
    m_busy = 0; m_g = 0; m_ptr = 0;
  endtask
  task automatic test_random();
    logic [N-1:0] er;
    logic         ep;
    logic [DW-1:0] ed;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        req_last[i]  = ($urandom_range(0, 9) < 3);
      end
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 9) < 2);
      abort     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      ep = m_accept();
      er = (m_busy != 0 && !fifo_full && !abort) ? (N'(1) << m_g) : '0;
      ed = ep ? req_data[m_g*DW +: DW] : '0;
      checks++;
      if (req_ready !== er || fifo_push !== ep || fifo_wdata !== ed || gnt_valid !== (m_busy != 0) || gnt_idx !== BW'(m_g)) begin
        errors++;
        $display("FAIL random[%0d]: ready=%b push=%b data=%0h gv=%b idx=%0d want %b/%b/%0h/%0d/%0d", c, req_ready, fifo_push, fifo_wdata, gnt_valid, gnt_idx, er, ep, ed, m_busy, m_g);
      end
      advance();
    end
    abort = 0;
  endtask
  initial begin
    test_reset();
    test_packets();
    test_wrap();
    test_full();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
